ppm16_rx_ctrl: RTL
==================

# ppm16_rx_ctrl

Receive-session controller that sequences `ppm16_demod`. It arms the demodulator and programs its correlation threshold. It times out and retries with a lowered threshold when no packet is found. It packs the demodulated nibbles into bytes and delivers them through a small FIFO with a valid/ready handshake. It sits between the demodulator and the downstream packet/byte consumer.

## Interface
- `CHIP_BITS`, 4: chip width; must match `ppm16_demod`.
- `TIMEOUT_BITS`, 16: width of the timeout counter.
- `MAX_RETRIES`, 3: threshold-lowering retries per session.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two.

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: level; high requests a session, low aborts.
- `threshold_init` in CHIP_BITS: first-attempt threshold.
- `threshold_min` in CHIP_BITS: floor for retries.
- `timeout_cycles` in TIMEOUT_BITS: search and inter-nibble timeout.
- `expected_nibbles` in 8: payload length.
- `demod_rx_start` out 1: one-cycle arm pulse to the demod.
- `demod_corr_threshold` out CHIP_BITS: drives `corr_threshold_ext`.
- `demod_packet_detected` in 1.
- `demod_dout_valid` in 1.
- `demod_dout` in 4.
- `byte_data` out 8, `byte_valid` out 1, `byte_ready` in 1: FIFO head handshake.
- `busy` out 1: high while the session is active.
- `pkt_done` out 1: one-cycle pulse on success.
- `pkt_timeout` out 1: one-cycle pulse on final failure.
- `retries_used` out 2: retries consumed in the current or last session.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, START, SEARCH, RECEIVE, DONE, FAIL.
- IDLE: when `enable`=1, load threshold=`threshold_init`, clear retries, nibble count, `overflow` and the half-byte register, then go to START.
- START: `demod_rx_start`=1 for exactly this cycle. Clear the timeout counter, then go to SEARCH.
- SEARCH: the counter increments each cycle.
  - `demod_packet_detected`=1 goes to RECEIVE.
  - If the counter equals `timeout_cycles`-1 and threshold > `threshold_min` and retries < MAX_RETRIES: threshold -= 1, retries += 1, go to START.
  - If the counter expires and no retry is allowed: go to FAIL.
  - Detection and expiry in the same cycle: detection wins.
- RECEIVE: each `demod_dout_valid` captures one nibble, increments the count and clears the timeout counter.
  - Even-indexed nibble goes to the high half of the byte.
  - Odd-indexed nibble completes the byte, which is written to the FIFO.
  - Count reaching `expected_nibbles` goes to DONE. An odd final nibble is flushed as {nibble, 4'h0}.
  - Counter expiry goes to FAIL. Bytes already queued stay in the FIFO.
- `expected_nibbles`=0: detection goes straight to DONE; no bytes are written.
- DONE: `pkt_done` pulse, then IDLE. FAIL: `pkt_timeout` pulse, then IDLE.
- A new session starts only after `enable` is seen high in IDLE, so holding `enable` high re-arms immediately.
- `enable`=0 in any non-IDLE state goes to IDLE next cycle with no pulse. FIFO contents are kept.
- FIFO full on write: drop the byte and set `overflow`. A read and write in the same cycle while full is not a drop.
- `demod_dout_valid` outside RECEIVE is ignored.

## Timing
- Reset values: state IDLE; `demod_rx_start` 0; `demod_corr_threshold` {1'b1, zeros}; `byte_valid` 0; `byte_data` 0; `busy` 0; `pkt_done` 0; `pkt_timeout` 0; `retries_used` 0; `overflow` 0; FIFO empty.
- All outputs are registered.
- `demod_rx_start` goes high 1 cycle after `enable` is seen in IDLE. `demod_corr_threshold` is stable from that same cycle.
- Retry gap: from timeout to the next `demod_rx_start` is 1 cycle.
- Latency from a completing `demod_dout_valid` to `byte_valid` is 2 cycles on an empty FIFO.
- Byte transfer occurs when `byte_valid` && `byte_ready`. `byte_data` holds while it is valid and not yet accepted.
- Reset asserted mid-session clears everything immediately, with no pulses.

## Structure
- Shared package `ppm16_rx_pkg` holds:
  - the state enum `rx_state_t`;
  - the localparam threshold reset value;
  - the nibble-count width (8).
- Sub-module `ppm16_rx_fifo`: synchronous FIFO, 8-bit wide, FIFO_DEPTH entries, with full/empty flags. The FSM and byte packer stay in the top module.

## Test plan
- Clean packet: `expected_nibbles`=6, nibbles 1,2,3,4,5,6, `byte_ready`=1 → bytes 0x12, 0x34, 0x56; one `pkt_done` pulse; `retries_used`=0.
- No detection: `timeout_cycles`=20, init=8, min=6 → threshold goes 8, 7, 6 with two further `demod_rx_start` pulses; then `pkt_timeout`; `retries_used`=2.
- Odd length: `expected_nibbles`=3, nibbles A,B,C → bytes 0xAB, 0xC0.
- Backpressure: `byte_ready`=0, 12 nibbles (6 bytes) → first 4 bytes queued; `overflow`=1; releasing ready drains exactly those 4 bytes in order.
- Abort: drop `enable` after 2 of 8 nibbles → IDLE next cycle; no `pkt_done` or `pkt_timeout`; byte 0x?? retained.
- Same-cycle detection and timeout at `timeout_cycles`-1 → enters RECEIVE; no retry; threshold unchanged.

Source files
------------

// File: rtl/ppm16_rx_pkg.sv
// Shared types and constants for the ppm16 receive-session controller.
package ppm16_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSearch,
        StReceive,
        StDone,
        StFail
    } rx_state_t;

    // MSB-only pattern; the top takes its upper CHIP_BITS bits as the threshold reset value.
    localparam logic [31:0] ThrResetSeed = 32'h8000_0000;

    localparam int unsigned NibbleCntBits = 8;

endpackage

// File: rtl/ppm16_rx_fifo.sv
// Byte FIFO between the nibble packer and the downstream consumer.
// The head entry is presented directly; the empty flag is registered.
module ppm16_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty_q;
    logic          do_wr, do_rd;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && (cnt_q != '0);
    // A simultaneous read frees the slot, so a write into a full FIFO is still accepted.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/ppm16_rx_ctrl.sv
// Receive-session controller for ppm16_demod: arms the demod, retries with a lowered
// threshold on search timeout, packs nibbles into bytes and queues them in a FIFO.
module ppm16_rx_ctrl #(
    parameter int unsigned CHIP_BITS    = 4,
    parameter int unsigned TIMEOUT_BITS = 16,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [CHIP_BITS-1:0]    threshold_init,
    input  logic [CHIP_BITS-1:0]    threshold_min,
    input  logic [TIMEOUT_BITS-1:0] timeout_cycles,
    input  logic [7:0]              expected_nibbles,
    output logic                    demod_rx_start,
    output logic [CHIP_BITS-1:0]    demod_corr_threshold,
    input  logic                    demod_packet_detected,
    input  logic                    demod_dout_valid,
    input  logic [3:0]              demod_dout,
    output logic [7:0]              byte_data,
    output logic                    byte_valid,
    input  logic                    byte_ready,
    output logic                    busy,
    output logic                    pkt_done,
    output logic                    pkt_timeout,
    output logic [1:0]              retries_used,
    output logic                    overflow
);

    import ppm16_rx_pkg::*;

    localparam logic [CHIP_BITS-1:0] ThrReset = ThrResetSeed[31 -: CHIP_BITS];

    rx_state_t                state_q;
    logic [TIMEOUT_BITS-1:0]  tmo_cnt_q;
    logic [NibbleCntBits-1:0] nib_cnt_q;
    logic [3:0]               hi_nib_q;
    logic                     wr_en_q;
    logic [7:0]               wr_data_q;
    logic                     fifo_full, fifo_empty, fifo_rd;
    logic                     tmo_hit, retry_ok, last_nib;

    assign tmo_hit  = (tmo_cnt_q == timeout_cycles - TIMEOUT_BITS'(1));
    assign retry_ok = (demod_corr_threshold > threshold_min) &&
                      (32'(retries_used) < MAX_RETRIES);
    assign last_nib = ((nib_cnt_q + NibbleCntBits'(1)) == expected_nibbles);

    assign byte_valid = !fifo_empty;
    assign fifo_rd    = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q              <= StIdle;
            tmo_cnt_q            <= '0;
            nib_cnt_q            <= '0;
            hi_nib_q             <= 4'h0;
            wr_en_q              <= 1'b0;
            wr_data_q            <= 8'h00;
            demod_rx_start       <= 1'b0;
            demod_corr_threshold <= ThrReset;
            busy                 <= 1'b0;
            pkt_done             <= 1'b0;
            pkt_timeout          <= 1'b0;
            retries_used         <= 2'd0;
            overflow             <= 1'b0;
        end else begin
            wr_en_q        <= 1'b0;
            demod_rx_start <= 1'b0;
            pkt_done       <= 1'b0;
            pkt_timeout    <= 1'b0;
            if (state_q != StIdle && !enable) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (enable) begin
                            state_q              <= StStart;
                            demod_corr_threshold <= threshold_init;
                            retries_used         <= 2'd0;
                            nib_cnt_q            <= '0;
                            hi_nib_q             <= 4'h0;
                            overflow             <= 1'b0;
                            demod_rx_start       <= 1'b1;
                            busy                 <= 1'b1;
                        end
                    end
                    StStart: begin
                        tmo_cnt_q <= '0;
                        state_q   <= StSearch;
                    end
                    StSearch: begin
                        if (demod_packet_detected) begin
                            tmo_cnt_q <= '0;
                            if (expected_nibbles == 8'd0) begin
                                state_q  <= StDone;
                                pkt_done <= 1'b1;
                            end else begin
                                state_q <= StReceive;
                            end
                        end else if (tmo_hit) begin
                            if (retry_ok) begin
                                demod_corr_threshold <= demod_corr_threshold - CHIP_BITS'(1);
                                retries_used         <= retries_used + 2'd1;
                                demod_rx_start       <= 1'b1;
                                state_q              <= StStart;
                            end else begin
                                pkt_timeout <= 1'b1;
                                state_q     <= StFail;
                            end
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TIMEOUT_BITS'(1);
                        end
                    end
                    StReceive: begin
                        if (demod_dout_valid) begin
                            tmo_cnt_q <= '0;
                            nib_cnt_q <= nib_cnt_q + NibbleCntBits'(1);
                            if (!nib_cnt_q[0]) begin
                                hi_nib_q <= demod_dout;
                            end else begin
                                wr_en_q   <= 1'b1;
                                wr_data_q <= {hi_nib_q, demod_dout};
                            end
                            if (last_nib) begin
                                state_q  <= StDone;
                                pkt_done <= 1'b1;
                                // Odd-length payload: flush the lone nibble as a high half.
                                if (!nib_cnt_q[0]) begin
                                    wr_en_q   <= 1'b1;
                                    wr_data_q <= {demod_dout, 4'h0};
                                end
                            end
                        end else if (tmo_hit) begin
                            pkt_timeout <= 1'b1;
                            state_q     <= StFail;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TIMEOUT_BITS'(1);
                        end
                    end
                    StDone, StFail: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
            // A dropped byte must stay visible even if a new session is armed on this edge.
            if (wr_en_q && fifo_full && !fifo_rd) begin
                overflow <= 1'b1;
            end
        end
    end

    ppm16_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (wr_en_q),
        .wr_data(wr_data_q),
        .rd_en  (fifo_rd),
        .rd_data(byte_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule
